// File: rtl/data_arith_extend_sched_pkg.sv
// Shared types and width helpers for the round-robin extender scheduler.
// Tags and credit counters size themselves from these helpers.
package data_arith_extend_sched_pkg;

  typedef struct packed {
    logic clk;
    logic rst_n;
  } data_control_t;

  typedef enum logic {
    SU_UNSIGNED = 1'b0,
    SU_SIGNED   = 1'b1
  } data_arith_signed_unsigned_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/data_arith_extend_sched_fifo.sv
// First-word fall-through response queue with occupancy count.
// Storage is not reset; only pointers and count are.
module data_arith_extend_sched_fifo
  import data_arith_extend_sched_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [W-1:0]                   wr_data,
  input  logic                           rd_en,
  output logic [W-1:0]                   rd_data,
  output logic                           valid,
  output logic [credit_width(DEPTH)-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = credit_width(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign valid   = (count != '0);
  assign pop     = rd_en && valid;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= next_ptr(wr_ptr);
      if (pop)   rd_ptr <= next_ptr(rd_ptr);
      if (wr_en && !pop)      count <= count + CNT_W'(1);
      else if (!wr_en && pop) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/data_arith_extend_sched.sv
// Round-robin scheduler sharing one fixed-latency sign/zero extender among N
// requesters; results are steered back to per-requester FWFT queues by tag.
module data_arith_extend_sched
  import data_arith_extend_sched_pkg::*;
#(
  parameter int N         = 2,
  parameter int IN_W      = 4,
  parameter int OUT_W     = 8,
  parameter int EXT_LAT   = 1,
  parameter int RSP_DEPTH = 2
) (
  input  data_control_t                         ctrl,
  input  logic [N-1:0]                          req_valid,
  output logic [N-1:0]                          req_ready,
  input  logic [N-1:0][IN_W-1:0]                req_data,
  input  data_arith_signed_unsigned_t [N-1:0]   req_sign,
  output logic [IN_W-1:0]                       ext_in,
  output data_arith_signed_unsigned_t           ext_sign,
  input  logic [OUT_W-1:0]                      ext_out,
  output logic [N-1:0]                          rsp_valid,
  input  logic [N-1:0]                          rsp_ready,
  output logic [N-1:0][OUT_W-1:0]               rsp_data
);
  localparam int ID_W   = id_width(N);
  localparam int CRED_W = credit_width(RSP_DEPTH);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  logic clk;
  logic rst_n;
  assign clk   = ctrl.clk;
  assign rst_n = ctrl.rst_n;

  tag_t                   tag_p [EXT_LAT];
  logic [ID_W-1:0]        last_grant;
  logic [N-1:0][CRED_W-1:0] count;
  logic [N-1:0][CRED_W-1:0] credit;
  logic [N-1:0]           eligible;
  logic [N-1:0]           grant;
  logic [N-1:0]           wr_en;
  logic [N-1:0]           rd_en;
  logic [ID_W-1:0]        gid;
  logic                   gvld;

  // Credit = free queue slots not already claimed by an in-flight operation.
  always_comb begin
    int used;
    used     = 0;
    credit   = '0;
    eligible = '0;
    for (int i = 0; i < N; i++) begin
      used = int'(count[i]);
      for (int s = 0; s < EXT_LAT; s++)
        if (tag_p[s].vld && int'(tag_p[s].id) == i) used++;
      credit[i]   = CRED_W'(RSP_DEPTH - used);
      eligible[i] = rst_n && req_valid[i] && (credit[i] != '0);
    end
  end

  always_comb begin
    int idx;
    idx   = 0;
    gvld  = 1'b0;
    gid   = '0;
    grant = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant) + k) % N;
      if (!gvld && eligible[idx]) begin
        gvld = 1'b1;
        gid  = ID_W'(idx);
      end
    end
    if (gvld) grant[gid] = 1'b1;
  end

  assign req_ready = grant;
  assign ext_in    = gvld ? req_data[gid] : '0;
  assign ext_sign  = gvld ? req_sign[gid] : SU_UNSIGNED;

  // Stage boundary: tag pipeline mirrors the extender's EXT_LAT registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ID_W'(N - 1);
      for (int s = 0; s < EXT_LAT; s++) tag_p[s] <= '0;
    end else begin
      if (gvld) last_grant <= gid;
      tag_p[0] <= '{vld: gvld, id: gid};
      for (int s = 1; s < EXT_LAT; s++) tag_p[s] <= tag_p[s-1];
    end
  end

  // Stage boundary: extender output lands in the tagged requester's queue.
  for (genvar i = 0; i < N; i++) begin : g_q
    assign wr_en[i] = tag_p[EXT_LAT-1].vld && (int'(tag_p[EXT_LAT-1].id) == i);
    assign rd_en[i] = rsp_valid[i] && rsp_ready[i];

    data_arith_extend_sched_fifo #(
      .W     (OUT_W),
      .DEPTH (RSP_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en[i]),
      .wr_data (ext_out),
      .rd_en   (rd_en[i]),
      .rd_data (rsp_data[i]),
      .valid   (rsp_valid[i]),
      .count   (count[i])
    );
  end

endmodule

// File: tb/tb_data_arith_extend_sched.sv
// Directed bench for data_arith_extend_sched with a 1-cycle extender model.
module tb_data_arith_extend_sched;
  import data_arith_extend_sched_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  data_control_t ctrl;
  assign ctrl = '{clk, rst_n};

  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0][3:0]  req_data;
  data_arith_signed_unsigned_t [1:0] req_sign;
  logic [3:0]       ext_in;
  data_arith_signed_unsigned_t ext_sign;
  logic [7:0]       ext_out;
  logic [1:0][7:0]  rsp_data;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_arith_extend_sched #(
    .N(2), .IN_W(4), .OUT_W(8), .EXT_LAT(1), .RSP_DEPTH(2)
  ) dut (
    .ctrl      (ctrl),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_sign  (req_sign),
    .ext_in    (ext_in),
    .ext_sign  (ext_sign),
    .ext_out   (ext_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data)
  );

  // Extender model: one register stage.
  always @(posedge clk)
    ext_out <= (ext_sign == SU_SIGNED) ? {{4{ext_in[3]}}, ext_in} : {4'h0, ext_in};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic [1:0] v, input logic [3:0] d0, input logic s0,
                     input logic [3:0] d1, input logic s1, input logic [1:0] rr);
    @(negedge clk);
    req_valid   = v;
    req_data[0] = d0;
    req_data[1] = d1;
    req_sign[0] = data_arith_signed_unsigned_t'(s0);
    req_sign[1] = data_arith_signed_unsigned_t'(s1);
    rsp_ready   = rr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Occupancy model: a write into a queue already holding 2 without a pop is an overflow.
  logic pend_vld;
  logic pend_id;
  int   occ [2];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld <= 1'b0;
      pend_id  <= 1'b0;
      occ[0]   <= 0;
      occ[1]   <= 0;
    end else begin
      pend_vld <= |req_ready;
      pend_id  <= req_ready[1];
      for (int i = 0; i < 2; i++) begin
        if (pend_vld && int'(pend_id) == i) begin
          n_chk++;
          if (occ[i] >= 2 && !(rsp_valid[i] && rsp_ready[i])) begin
            n_fail++;
            $display("FAIL overflow_q%0d: occupancy %0d, required below 2", i, occ[i]);
          end
        end
        occ[i] <= occ[i] + ((pend_vld && int'(pend_id) == i) ? 1 : 0)
                         - ((rsp_valid[i] && rsp_ready[i]) ? 1 : 0);
      end
    end
  end

  typedef struct packed {
    logic [1:0] vld;
    logic [3:0] d0;
    logic       s0;
    logic [3:0] d1;
    logic       s1;
    logic [1:0] rr;
    logic [1:0] e_rdy;
    logic [3:0] e_ext;
    logic       e_es;
    logic [1:0] e_rv;
    logic [7:0] e_r0;
    logic [7:0] e_r1;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int g1;
    // Alternating grants from reset, both requesters signed.
    tbl[0]  = '{2'b11, 4'h5, 1'b1, 4'h8, 1'b1, 2'b11, 2'b01, 4'h5, 1'b1, 2'b00, 8'h00, 8'h00};
    tbl[1]  = '{2'b11, 4'h5, 1'b1, 4'h8, 1'b1, 2'b11, 2'b10, 4'h8, 1'b1, 2'b00, 8'h00, 8'h00};
    tbl[2]  = '{2'b11, 4'h5, 1'b1, 4'h8, 1'b1, 2'b11, 2'b01, 4'h5, 1'b1, 2'b01, 8'h05, 8'h00};
    tbl[3]  = '{2'b11, 4'h5, 1'b1, 4'h8, 1'b1, 2'b11, 2'b10, 4'h8, 1'b1, 2'b10, 8'h00, 8'hf8};
    tbl[4]  = '{2'b00, 4'h0, 1'b0, 4'h0, 1'b0, 2'b11, 2'b00, 4'h0, 1'b0, 2'b01, 8'h05, 8'h00};
    tbl[5]  = '{2'b00, 4'h0, 1'b0, 4'h0, 1'b0, 2'b11, 2'b00, 4'h0, 1'b0, 2'b10, 8'h00, 8'hf8};
    tbl[6]  = '{2'b00, 4'h0, 1'b0, 4'h0, 1'b0, 2'b11, 2'b00, 4'h0, 1'b0, 2'b00, 8'h00, 8'h00};
    // Same value, signed then unsigned.
    tbl[7]  = '{2'b01, 4'ha, 1'b1, 4'h0, 1'b0, 2'b11, 2'b01, 4'ha, 1'b1, 2'b00, 8'h00, 8'h00};
    tbl[8]  = '{2'b01, 4'ha, 1'b0, 4'h0, 1'b0, 2'b11, 2'b01, 4'ha, 1'b0, 2'b00, 8'h00, 8'h00};
    tbl[9]  = '{2'b00, 4'h0, 1'b0, 4'h0, 1'b0, 2'b11, 2'b00, 4'h0, 1'b0, 2'b01, 8'hfa, 8'h00};
    tbl[10] = '{2'b00, 4'h0, 1'b0, 4'h0, 1'b0, 2'b11, 2'b00, 4'h0, 1'b0, 2'b01, 8'h0a, 8'h00};
    tbl[11] = '{2'b00, 4'h0, 1'b0, 4'h0, 1'b0, 2'b11, 2'b00, 4'h0, 1'b0, 2'b00, 8'h00, 8'h00};

    req_valid = 2'b00;
    req_data  = '0;
    req_sign  = {SU_UNSIGNED, SU_UNSIGNED};
    rsp_ready = 2'b00;

    // Reset held with both requesters pending.
    for (int k = 0; k < 2; k++) begin
      cyc(2'b11, 4'h3, 1'b0, 4'hc, 1'b1, 2'b11);
      chk("rst_req_ready", req_ready, 2'b00);
      chk("rst_rsp_valid", rsp_valid, 2'b00);
      chk("rst_ext_in", ext_in, 4'h0);
      chk("rst_ext_sign", ext_sign, SU_UNSIGNED);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("first_grant", req_ready, 2'b01);
    chk("first_ext_in", ext_in, 4'h3);
    chk("first_ext_sign", ext_sign, SU_UNSIGNED);
    cyc(2'b11, 4'h3, 1'b0, 4'hc, 1'b1, 2'b11);
    chk("second_grant", req_ready, 2'b10);
    chk("second_ext_in", ext_in, 4'hc);
    chk("second_ext_sign", ext_sign, SU_SIGNED);
    for (int k = 0; k < 3; k++) cyc(2'b00, 4'h0, 1'b0, 4'h0, 1'b0, 2'b11);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].vld, tbl[i].d0, tbl[i].s0, tbl[i].d1, tbl[i].s1, tbl[i].rr);
      chk($sformatf("tbl%0d_req_ready", i), req_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_ext_in", i), ext_in, tbl[i].e_ext);
      chk($sformatf("tbl%0d_ext_sign", i), ext_sign, tbl[i].e_es);
      chk($sformatf("tbl%0d_rsp_valid", i), rsp_valid, tbl[i].e_rv);
      if (tbl[i].e_rv[0]) chk($sformatf("tbl%0d_rsp_data0", i), rsp_data[0], tbl[i].e_r0);
      if (tbl[i].e_rv[1]) chk($sformatf("tbl%0d_rsp_data1", i), rsp_data[1], tbl[i].e_r1);
    end

    // Requester 0 stalled on its response queue.
    cyc(2'b11, 4'h1, 1'b0, 4'h2, 1'b0, 2'b10);
    chk("stall_c0_ready", req_ready, 2'b10);
    cyc(2'b11, 4'h1, 1'b0, 4'h2, 1'b0, 2'b10);
    chk("stall_c1_ready", req_ready, 2'b01);
    cyc(2'b11, 4'h3, 1'b0, 4'h2, 1'b0, 2'b10);
    chk("stall_c2_ready", req_ready, 2'b10);
    cyc(2'b11, 4'h3, 1'b0, 4'h2, 1'b0, 2'b10);
    chk("stall_c3_ready", req_ready, 2'b01);
    g1 = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(2'b11, 4'h7, 1'b0, 4'h2, 1'b0, 2'b10);
      chk("stall_req0_blocked", req_ready[0], 1'b0);
      if (req_ready[1]) g1++;
    end
    chk("stall_req1_served", (g1 >= 2), 1'b1);
    cyc(2'b01, 4'h7, 1'b0, 4'h0, 1'b0, 2'b11);
    chk("drain_rv0_a", rsp_valid[0], 1'b1);
    chk("drain_data0_a", rsp_data[0], 8'h01);
    chk("drain_noregrant", req_ready[0], 1'b0);
    cyc(2'b01, 4'h7, 1'b0, 4'h0, 1'b0, 2'b11);
    chk("drain_regrant", req_ready, 2'b01);
    chk("drain_rv0_b", rsp_valid[0], 1'b1);
    chk("drain_data0_b", rsp_data[0], 8'h03);
    cyc(2'b00, 4'h0, 1'b0, 4'h0, 1'b0, 2'b11);
    chk("drain_gap", rsp_valid[0], 1'b0);
    cyc(2'b00, 4'h0, 1'b0, 4'h0, 1'b0, 2'b11);
    chk("drain_rv0_c", rsp_valid[0], 1'b1);
    chk("drain_data0_c", rsp_data[0], 8'h07);
    cyc(2'b00, 4'h0, 1'b0, 4'h0, 1'b0, 2'b11);
    cyc(2'b00, 4'h0, 1'b0, 4'h0, 1'b0, 2'b11);

    // Reset with one result queued and one in flight.
    cyc(2'b01, 4'h4, 1'b0, 4'h0, 1'b0, 2'b00);
    chk("mid_acc0", req_ready, 2'b01);
    cyc(2'b01, 4'h6, 1'b0, 4'h0, 1'b0, 2'b00);
    chk("mid_acc1", req_ready, 2'b01);
    cyc(2'b00, 4'h0, 1'b0, 4'h0, 1'b0, 2'b00);
    chk("mid_queued", rsp_valid, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rv", rsp_valid, 2'b00);
    cyc(2'b11, 4'h4, 1'b0, 4'h6, 1'b0, 2'b00);
    chk("mid_rst_ready", req_ready, 2'b00);
    chk("mid_rst_ext_in", ext_in, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b00;
    #1;
    chk("mid_rel_rv", rsp_valid, 2'b00);
    for (int k = 0; k < 3; k++) begin
      cyc(2'b00, 4'h0, 1'b0, 4'h0, 1'b0, 2'b11);
      chk("mid_no_stale", rsp_valid, 2'b00);
    end

    // Simultaneous pop and write with one entry queued.
    cyc(2'b01, 4'h9, 1'b0, 4'h0, 1'b0, 2'b00);
    chk("pw_acc0", req_ready, 2'b01);
    cyc(2'b01, 4'hb, 1'b1, 4'h0, 1'b0, 2'b00);
    chk("pw_acc1", req_ready, 2'b01);
    cyc(2'b00, 4'h0, 1'b0, 4'h0, 1'b0, 2'b01);
    chk("pw_rv_a", rsp_valid, 2'b01);
    chk("pw_data_a", rsp_data[0], 8'h09);
    cyc(2'b00, 4'h0, 1'b0, 4'h0, 1'b0, 2'b01);
    chk("pw_rv_b", rsp_valid, 2'b01);
    chk("pw_data_b", rsp_data[0], 8'hfb);
    cyc(2'b00, 4'h0, 1'b0, 4'h0, 1'b0, 2'b00);
    chk("pw_empty", rsp_valid, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
